// File: rtl/ioctl_word_packer.sv
// Packs the data_io ioctl byte stream into DATA_BYTES-wide words with byte enables and buffers
// them, tagged with a channel, in a small FIFO toward a ready/valid memory writer.
module ioctl_word_packer #(
  parameter int unsigned DATA_BYTES = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned CHAN_BITS  = 2
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            ioctl_download,
  input  logic [7:0]                      ioctl_index,
  input  logic                            ioctl_wr,
  input  logic [26:0]                     ioctl_addr,
  input  logic [7:0]                      ioctl_dout,
  output logic                            ioctl_wait,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [26-$clog2(DATA_BYTES):0]  out_addr,
  output logic [8*DATA_BYTES-1:0]         out_data,
  output logic [DATA_BYTES-1:0]           out_be,
  output logic [CHAN_BITS-1:0]            out_chan,
  output logic                            done,
  output logic                            overflow
);

  localparam int unsigned LB = $clog2(DATA_BYTES);
  localparam int unsigned LW = (LB == 0) ? 1 : LB;
  localparam int unsigned AW = 27 - LB;
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WaitCnt = CW'(FIFO_DEPTH - 2);
  localparam logic [DATA_BYTES-1:0] BeAll = '1;

  logic                  dl_q, overflow_q, overflow_d, done_q, done_pend_q, done_pend_d;
  logic                  wait_q, wait_d, out_valid_q, out_valid_d;
  logic [CHAN_BITS-1:0]  chan_q, chan_d;
  logic                  acc_valid_q, acc_valid_d, acc_full_q, acc_full_d;
  logic [AW-1:0]         acc_waddr_q, acc_waddr_d;
  logic [DW-1:0]         acc_data_q, acc_data_d;
  logic [DATA_BYTES-1:0] acc_be_q, acc_be_d;
  logic [CHAN_BITS-1:0]  acc_chan_q, acc_chan_d;
  logic                  stg_valid_q, stg_valid_d;
  logic [AW-1:0]         stg_waddr_q, stg_waddr_d;
  logic [DW-1:0]         stg_data_q, stg_data_d;
  logic [DATA_BYTES-1:0] stg_be_q, stg_be_d;
  logic [CHAN_BITS-1:0]  stg_chan_q, stg_chan_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [AW-1:0]         mem_waddr_q [FIFO_DEPTH];
  logic [DW-1:0]         mem_data_q  [FIFO_DEPTH];
  logic [DATA_BYTES-1:0] mem_be_q    [FIFO_DEPTH];
  logic [CHAN_BITS-1:0]  mem_chan_q  [FIFO_DEPTH];

  logic                  rise, fall, pop, push, stg_free, wr_en, drop, wr_ok, disc, evict;
  logic                  base_valid, mrg_full, fire;
  logic [AW-1:0]         wr_waddr;
  logic [LW-1:0]         lane, pos;
  logic [CHAN_BITS-1:0]  cur_chan, mrg_chan;
  logic [DW-1:0]         mrg_data;
  logic [DATA_BYTES-1:0] mrg_be;

  logic unused_index;
  assign unused_index = ^ioctl_index[7:CHAN_BITS];

  always_comb begin
    rise       = ioctl_download & ~dl_q;
    fall       = ~ioctl_download & dl_q;
    cur_chan   = rise ? ioctl_index[CHAN_BITS-1:0] : chan_q;
    pop        = out_valid_q & out_ready;
    push       = stg_valid_q & ((cnt_q != FullCnt) | pop);
    stg_free   = ~stg_valid_q | push;
    wr_en      = ioctl_wr & ioctl_download;
    drop       = wr_en & (cnt_q == FullCnt) & stg_valid_q;
    // A byte that is not dropped always finds staging free this cycle.
    wr_ok      = wr_en & ~drop;
    wr_waddr   = ioctl_addr[26:LB];
    lane       = (DATA_BYTES == 1) ? '0 : ioctl_addr[LW-1:0];
    pos        = BIG_ENDIAN ? (LW'(DATA_BYTES - 1) - lane) : lane;
    disc       = wr_ok & acc_valid_q & (wr_waddr != acc_waddr_q);
    evict      = stg_free & acc_valid_q & (acc_full_q | ~ioctl_download | disc);
    base_valid = acc_valid_q & ~evict;
    mrg_data   = base_valid ? acc_data_q : '0;
    mrg_data[{pos, 3'b000} +: 8] = ioctl_dout;
    mrg_be     = (base_valid ? acc_be_q : '0) | (DATA_BYTES'(1) << pos);
    mrg_full   = (mrg_be == BeAll);
    mrg_chan   = base_valid ? acc_chan_q : cur_chan;
  end

  always_comb begin
    acc_valid_d = acc_valid_q;
    acc_full_d  = acc_full_q;
    acc_waddr_d = acc_waddr_q;
    acc_data_d  = acc_data_q;
    acc_be_d    = acc_be_q;
    acc_chan_d  = acc_chan_q;
    stg_valid_d = stg_valid_q & ~push;
    stg_waddr_d = stg_waddr_q;
    stg_data_d  = stg_data_q;
    stg_be_d    = stg_be_q;
    stg_chan_d  = stg_chan_q;
    if (evict) begin
      stg_valid_d = 1'b1;
      stg_waddr_d = acc_waddr_q;
      stg_data_d  = acc_data_q;
      stg_be_d    = acc_be_q;
      stg_chan_d  = acc_chan_q;
      acc_valid_d = 1'b0;
      acc_full_d  = 1'b0;
      acc_data_d  = '0;
      acc_be_d    = '0;
    end
    if (wr_ok) begin
      if (mrg_full && !evict) begin
        stg_valid_d = 1'b1;
        stg_waddr_d = wr_waddr;
        stg_data_d  = mrg_data;
        stg_be_d    = mrg_be;
        stg_chan_d  = mrg_chan;
        acc_valid_d = 1'b0;
        acc_full_d  = 1'b0;
        acc_data_d  = '0;
        acc_be_d    = '0;
      end else begin
        // A full word that cannot reach staging yet is parked until the next cycle.
        acc_valid_d = 1'b1;
        acc_full_d  = mrg_full;
        acc_waddr_d = wr_waddr;
        acc_data_d  = mrg_data;
        acc_be_d    = mrg_be;
        acc_chan_d  = mrg_chan;
      end
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    out_valid_d = (cnt_d != '0);
    wait_d      = (cnt_d >= WaitCnt) | stg_valid_d | acc_full_d;
    chan_d      = cur_chan;
    overflow_d  = (rise ? 1'b0 : overflow_q) | drop;
    fire        = done_pend_q & ~rise & ~acc_valid_q & ~stg_valid_q & (cnt_q == '0);
    done_pend_d = done_pend_q;
    if (rise || fire) begin
      done_pend_d = 1'b0;
    end else if (fall) begin
      done_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_waddr_q[wr_ptr_q] <= stg_waddr_q;
      mem_data_q[wr_ptr_q]  <= stg_data_q;
      mem_be_q[wr_ptr_q]    <= stg_be_q;
      mem_chan_q[wr_ptr_q]  <= stg_chan_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q        <= 1'b0;
      chan_q      <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
      wait_q      <= 1'b0;
      out_valid_q <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_full_q  <= 1'b0;
      acc_waddr_q <= '0;
      acc_data_q  <= '0;
      acc_be_q    <= '0;
      acc_chan_q  <= '0;
      stg_valid_q <= 1'b0;
      stg_waddr_q <= '0;
      stg_data_q  <= '0;
      stg_be_q    <= '0;
      stg_chan_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      dl_q        <= ioctl_download;
      chan_q      <= chan_d;
      overflow_q  <= overflow_d;
      done_q      <= fire;
      done_pend_q <= done_pend_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      acc_valid_q <= acc_valid_d;
      acc_full_q  <= acc_full_d;
      acc_waddr_q <= acc_waddr_d;
      acc_data_q  <= acc_data_d;
      acc_be_q    <= acc_be_d;
      acc_chan_q  <= acc_chan_d;
      stg_valid_q <= stg_valid_d;
      stg_waddr_q <= stg_waddr_d;
      stg_data_q  <= stg_data_d;
      stg_be_q    <= stg_be_d;
      stg_chan_q  <= stg_chan_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    ioctl_wait = wait_q;
    out_valid  = out_valid_q;
    done       = done_q;
    overflow   = overflow_q;
    out_addr   = out_valid_q ? mem_waddr_q[rd_ptr_q] : '0;
    out_data   = out_valid_q ? mem_data_q[rd_ptr_q] : '0;
    out_be     = out_valid_q ? mem_be_q[rd_ptr_q] : '0;
    out_chan   = out_valid_q ? mem_chan_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_ioctl_word_packer.sv
// Directed bench for ioctl_word_packer: a word-level reference model feeds a scoreboard that is
// checked on every pop; literal expectations pin the model and the DATA_BYTES=4 big-endian path.
module tb_ioctl_word_packer;

  typedef struct packed {
    logic [25:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [1:0]  ch;
  } word_t;

  typedef struct packed {
    logic [24:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [1:0]  ch;
  } word4_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, dl, wr, rdy;
  logic [7:0]  idx, dout;
  logic [26:0] addr;
  logic        wt, ovld, done, ov;
  logic [25:0] oaddr;
  logic [15:0] odata;
  logic [1:0]  obe, ochan;

  logic        d4_dl, d4_wr, d4_rdy;
  logic [7:0]  d4_idx, d4_dout;
  logic [26:0] d4_addr;
  logic        d4_wt, d4_ovld, d4_done, d4_ov;
  logic [24:0] d4_oaddr;
  logic [31:0] d4_odata;
  logic [3:0]  d4_obe;
  logic [1:0]  d4_ochan;

  ioctl_word_packer u_dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wt), .out_valid(ovld), .out_ready(rdy),
    .out_addr(oaddr), .out_data(odata), .out_be(obe), .out_chan(ochan), .done(done),
    .overflow(ov)
  );

  ioctl_word_packer #(.DATA_BYTES(4), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b1), .CHAN_BITS(2)) u_dut4 (
    .clk_sys(clk), .reset(reset), .ioctl_download(d4_dl), .ioctl_index(d4_idx),
    .ioctl_wr(d4_wr), .ioctl_addr(d4_addr), .ioctl_dout(d4_dout), .ioctl_wait(d4_wt),
    .out_valid(d4_ovld), .out_ready(d4_rdy), .out_addr(d4_oaddr), .out_data(d4_odata),
    .out_be(d4_obe), .out_chan(d4_ochan), .done(d4_done), .overflow(d4_ov)
  );

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int done4_cnt = 0;

  word_t  exp_q[$];
  word_t  log_q[$];
  word4_t log4_q[$];
  bit     m_valid = 1'b0;
  word_t  m_w = '0;
  logic [1:0] cur_chan = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level model: bytes of one word address collect until the word fills, the address
  // changes, or the download ends.
  task automatic m_emit();
    exp_q.push_back(m_w);
    m_valid = 1'b0;
    m_w = '0;
  endtask

  task automatic m_byte(input logic [26:0] a, input logic [7:0] d);
    logic [25:0] wa;
    wa = a[26:1];
    if (m_valid && wa != m_w.a) m_emit();
    if (!m_valid) begin
      m_valid = 1'b1;
      m_w = '0;
      m_w.a = wa;
      m_w.ch = cur_chan;
    end
    if (a[0]) m_w.d[15:8] = d;
    else m_w.d[7:0] = d;
    m_w.be[a[0]] = 1'b1;
    if (m_w.be == 2'b11) m_emit();
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (d4_done) done4_cnt++;
    if (!reset && d4_ovld && d4_rdy) log4_q.push_back({d4_oaddr, d4_odata, d4_obe, d4_ochan});
    if (!reset && ovld && rdy) begin
      log_q.push_back({oaddr, odata, obe, ochan});
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got 0x%0h, want none", {oaddr, odata, obe, ochan});
      end else begin
        chk("word", {oaddr, odata, obe, ochan}, exp_q.pop_front());
      end
    end
  end

  task automatic start_dl(input logic [7:0] index);
    idx = index;
    dl = 1'b1;
    cur_chan = index[1:0];
    tick();
  endtask

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d, input bit honour,
                         input bit accept);
    int budget;
    budget = 200;
    while (honour && wt && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_chk++;
      $display("FAIL wait_timeout: ioctl_wait stuck at 1, want 0 within 200 cycles");
    end else begin
      wr = 1'b1;
      addr = a;
      dout = d;
      tick();
      wr = 1'b0;
      if (accept) m_byte(a, d);
    end
  endtask

  task automatic end_dl();
    int d0;
    dl = 1'b0;
    if (m_valid) m_emit();
    d0 = done_cnt;
    repeat (40) tick();
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wr4(input logic [26:0] a, input logic [7:0] d);
    d4_wr = 1'b1;
    d4_addr = a;
    d4_dout = d;
    tick();
    d4_wr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; dl = 1'b0; wr = 1'b0; rdy = 1'b0; idx = 8'h00; dout = 8'h00; addr = '0;
    d4_dl = 1'b0; d4_wr = 1'b0; d4_rdy = 1'b0; d4_idx = 8'h00; d4_dout = 8'h00; d4_addr = '0;
    repeat (3) tick();
    chk("reset_flags", {60'd0, ovld, wt, done, ov}, 64'd0);
    chk("reset_addr", 64'(oaddr), 64'd0);
    chk("reset_data", 64'(odata), 64'd0);
    chk("reset_be_chan", {60'd0, obe, ochan}, 64'd0);
    reset = 1'b0;
    tick();

    // Basic packing, channel from index 0x41.
    rdy = 1'b1;
    log_q.delete();
    start_dl(8'h41);
    wr_byte(27'd0, 8'h11, 1'b1, 1'b1);
    wr_byte(27'd1, 8'h22, 1'b1, 1'b1);
    wr_byte(27'd2, 8'h33, 1'b1, 1'b1);
    wr_byte(27'd3, 8'h44, 1'b1, 1'b1);
    end_dl();
    chk("t1_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk("t1_word0", 64'(log_q[0]), 64'({26'd0, 16'h2211, 2'b11, 2'd1}));
      chk("t1_word1", 64'(log_q[1]), 64'({26'd1, 16'h4433, 2'b11, 2'd1}));
    end

    // Backpressure with the source honouring ioctl_wait.
    rdy = 1'b0;
    start_dl(8'h02);
    wr_byte(27'd0, 8'h60, 1'b1, 1'b1);
    wr_byte(27'd1, 8'h61, 1'b1, 1'b1);
    tick();
    chk("t2_wait_cnt1", 64'(wt), 64'd0);
    wr_byte(27'd2, 8'h62, 1'b1, 1'b1);
    wr_byte(27'd3, 8'h63, 1'b1, 1'b1);
    tick();
    tick();
    chk("t2_wait_cnt2", 64'(wt), 64'd1);
    chk("t2_valid", 64'(ovld), 64'd1);
    rdy = 1'b1;
    for (int i = 4; i < 8; i++) wr_byte(27'(i), 8'(8'h60 + i), 1'b1, 1'b1);
    end_dl();
    chk("t2_no_overflow", 64'(ov), 64'd0);

    // Source ignores ioctl_wait: bytes 10 and 11 find FIFO and staging full.
    rdy = 1'b0;
    start_dl(8'h03);
    for (int i = 0; i < 12; i++) wr_byte(27'(i), 8'(8'h50 + i), 1'b0, i < 10);
    chk("t3_overflow", 64'(ov), 64'd1);
    rdy = 1'b1;
    end_dl();
    chk("t3_overflow_sticky", 64'(ov), 64'd1);
    // Empty download: clears overflow and still produces a single done.
    start_dl(8'h00);
    tick();
    chk("t3_overflow_clear", 64'(ov), 64'd0);
    end_dl();

    // Discontinuity followed by a byte completing the new word.
    log_q.delete();
    start_dl(8'h01);
    wr_byte(27'd0, 8'hA0, 1'b0, 1'b1);
    wr_byte(27'd3, 8'hA3, 1'b0, 1'b1);
    wr_byte(27'd2, 8'hA2, 1'b0, 1'b1);
    chk("t4_wait_high", 64'(wt), 64'd1);
    end_dl();
    chk("t4_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk("t4_word0", 64'(log_q[0]), 64'({26'd0, 16'h00A0, 2'b01, 2'd1}));
      chk("t4_word1", 64'(log_q[1]), 64'({26'd1, 16'hA3A2, 2'b11, 2'd1}));
    end

    // Byte strobe outside a download is ignored.
    d0 = done_cnt;
    wr_byte(27'd5, 8'h77, 1'b0, 1'b0);
    repeat (10) tick();
    chk("t5_ignored_valid", 64'(ovld), 64'd0);
    chk("t5_ignored_done", 64'(done_cnt - d0), 64'd0);

    // Reset with three words buffered.
    rdy = 1'b0;
    start_dl(8'h02);
    for (int i = 0; i < 6; i++) wr_byte(27'(i), 8'(8'h30 + i), 1'b0, 1'b1);
    tick();
    tick();
    chk("t6_valid_before", 64'(ovld), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dl = 1'b0;
    chk("t6_valid_after", 64'(ovld), 64'd0);
    chk("t6_wait_after", 64'(wt), 64'd0);
    exp_q.delete();
    m_valid = 1'b0;
    m_w = '0;
    rdy = 1'b1;
    d0 = done_cnt;
    repeat (30) tick();
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);

    // DATA_BYTES=4, big-endian lane placement and end-of-download flush.
    d4_rdy = 1'b1;
    d4_idx = 8'h02;
    d4_dl = 1'b1;
    tick();
    wr4(27'd4, 8'hAA);
    wr4(27'd5, 8'hBB);
    wr4(27'd12, 8'hCC);
    d4_dl = 1'b0;
    repeat (30) tick();
    chk("t7_count", 64'(log4_q.size()), 64'd2);
    if (log4_q.size() >= 2) begin
      chk("t7_word0", 64'(log4_q[0]), 64'({25'd1, 32'hAABB0000, 4'b1100, 2'd2}));
      chk("t7_word1", 64'(log4_q[1]), 64'({25'd3, 32'hCC000000, 4'b1000, 2'd2}));
    end
    chk("t7_done_once", 64'(done4_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ioctl_word_packer.md
Name: ioctl_word_packer

Overview:
- Parametrised successor to the 8/16-bit ioctl download path.
- Takes the byte stream that data_io delivers on ioctl_wr/ioctl_addr/ioctl_dout and packs it into DATA_BYTES-wide words with byte enables.
- Tags each word with a channel taken from ioctl_index and buffers words in a FIFO toward a ready/valid memory writer (SDRAM/BRAM loader).
- Applies backpressure to the byte source through ioctl_wait and flushes partial words at discontinuities and at the end of a download.

Parameters:
- DATA_BYTES, 2, output word width in bytes; legal values 1, 2, 4, 8; LB = log2(DATA_BYTES).
- FIFO_DEPTH, 4, number of word entries in the output FIFO; power of two, at least 4.
- BIG_ENDIAN, 0, 0: lane L goes to out_data[8L+:8]; 1: lane L goes to out_data[8(DATA_BYTES-1-L)+:8].
- CHAN_BITS, 2, number of ioctl_index LSBs used as the channel tag.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active, level signal.
- ioctl_index  in  8  menu index; bits [CHAN_BITS-1:0] select the channel.
- ioctl_wr  in  1  byte strobe, one clk_sys cycle wide.
- ioctl_addr  in  27  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  asks the source to stop issuing ioctl_wr.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  sink accepts the head word.
- out_addr  out  27-LB  word address (ioctl_addr >> LB).
- out_data  out  8*DATA_BYTES  packed word.
- out_be  out  DATA_BYTES  byte enables, one bit per lane.
- out_chan  out  CHAN_BITS  channel tag.
- done  out  1  one-cycle pulse when a download has fully drained.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset: ioctl_wait=0, out_valid=0, done=0, overflow=0. Accumulator, staging register and FIFO are empty. out_addr, out_data, out_be and out_chan are 0.
- Download start (rising edge of ioctl_download): latch chan = ioctl_index[CHAN_BITS-1:0] and clear overflow.
- Lane is ioctl_addr[LB-1:0]. With DATA_BYTES=1, the lane is 0 and every byte forms a full word.
- The accumulator holds acc_waddr, acc_data, acc_be, acc_valid and acc_full.
- ioctl_wr handling:
  - If acc_valid and ioctl_addr>>LB != acc_waddr (discontinuity): move the old accumulator to staging with its partial byte enables, then start a new accumulator with this byte.
  - Otherwise merge the byte into its lane and set that be bit. Writing the same lane twice overwrites the byte; the be bit stays 1.
  - If the merged be is all ones: move the accumulator to staging in the same cycle and clear it.
  - If staging is being loaded by a discontinuity flush in that same cycle: keep the new full word with acc_full=1 and move it to staging on the next cycle.
- Staging register:
  - Single entry, drains into the FIFO on the cycle after it is loaded.
  - It never loads and drains in conflict: at most one FIFO push per cycle.
- FIFO:
  - Head drives the out_* signals. A pop happens on out_valid && out_ready.
  - A push and a pop in the same cycle leaves the count unchanged.
  - out_valid rises one cycle after the first push into an empty FIFO; it is registered.
- ioctl_wait = (count >= FIFO_DEPTH-2) || stg_valid || acc_full. The value is registered and updated every cycle.
- Overflow: an ioctl_wr arriving while the FIFO count is FIFO_DEPTH and staging is occupied drops the byte and sets overflow. Nothing else changes.
- Download end (falling edge of ioctl_download):
  - If acc_valid, flush the partial word through staging.
  - Once staging is empty, the FIFO is empty, and the accumulator is empty, pulse done for one cycle.
  - done fires exactly once per download, including downloads that contained no bytes.
- A new download starting before done fires:
  - Pending words still drain and keep their original channel.
  - The pending done is cancelled.
- reset asserted mid-download discards all buffered data. Outputs return to their reset values on the next clock edge.
- ioctl_wr while ioctl_download=0 is ignored.

Test Plan:
- DATA_BYTES=2, BIG_ENDIAN=0, index 0x41, bytes 0x11,0x22,0x33,0x44 at addresses 0..3, out_ready=1 -> two words: (addr 0, data 0x2211, be 11, chan 1), then (addr 1, data 0x4433, be 11); done pulses once after the download falls.
- DATA_BYTES=4, BIG_ENDIAN=1, bytes 0xAA at address 4, 0xBB at address 5, then 0xCC at address 12 -> word (addr 1, data 0xAABB0000, be 1100); the download end then flushes (addr 3, data 0x00000000CC placed in lane 0 per BIG_ENDIAN -> data 0xCC000000, be 1000).
- DATA_BYTES=2, out_ready=0, stream bytes honouring ioctl_wait -> ioctl_wait rises when count reaches 2 (FIFO_DEPTH=4); no byte lost; overflow stays 0.
- Same as the previous case but the source ignores ioctl_wait -> the first excess byte is dropped and overflow=1; a new download start clears overflow.
- Discontinuity into a full word: DATA_BYTES=2, byte at address 0, then byte at address 3, then byte at address 2 -> (addr 0, be 01) pushed first; (addr 1, be 11) pushed the next cycle with no loss; ioctl_wait is high for that cycle.
- reset asserted for one cycle with 3 words buffered -> out_valid=0 and ioctl_wait=0 next cycle; no done pulse follows.
